// File: rtl/tx_preamble_ins.sv
// GMII transmit framer: prepends preamble/SFD to an upstream frame body and enforces the inter-frame gap.
// Optional minimum-length zero padding is compiled in with `define TX_PAD_EN.
module tx_preamble_ins #(
    parameter int PRE_LEN = 7,
    parameter int IFG_LEN = 12,
    parameter int MIN_LEN = 60
) (
    input  logic       tx_clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy,
    output logic       underrun
);

    // state | meaning
    // IDLE  | waiting for in_valid to start a frame
    // PRE   | sending 0x55 preamble bytes
    // SFD   | sending 0xD5, first body byte accepted
    // DATA  | streaming body bytes, one per cycle
    // PAD   | zero fill up to MIN_LEN body bytes (TX_PAD_EN only)
    // IFG   | last byte/error byte on the wire, then tx_en low for IFG_LEN cycles

    if (PRE_LEN < 1 || PRE_LEN > 15) begin : g_bad_pre_len
        $error("tx_preamble_ins: PRE_LEN out of range 1..15");
    end
    if (IFG_LEN < 1 || IFG_LEN > 255) begin : g_bad_ifg_len
        $error("tx_preamble_ins: IFG_LEN out of range 1..255");
    end
    if (MIN_LEN < 1 || MIN_LEN > 2047) begin : g_bad_min_len
        $error("tx_preamble_ins: MIN_LEN out of range 1..2047");
    end

    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [3:0]  PRE_LOAD = 4'(PRE_LEN - 1);
    localparam logic [7:0]  IFG_LOAD = 8'(IFG_LEN);
    localparam logic [10:0] CNT_MAX  = 11'h7FF;

`ifdef TX_PAD_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        DATA = 3'd3,
        PAD  = 3'd4,
        IFG  = 3'd5
    } state_t;
    localparam logic [10:0] MIN_CNT = 11'(MIN_LEN);
    logic [10:0] pad_cnt, pad_cnt_n;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        DATA = 3'd3,
        IFG  = 3'd5
    } state_t;
`endif

    state_t      state, state_n;
    logic [3:0]  pre_cnt, pre_cnt_n;
    logic [7:0]  ifg_cnt, ifg_cnt_n;
    logic [10:0] byte_cnt, byte_cnt_n;
    logic [10:0] byte_inc;
    logic [7:0]  tx_data_n;
    logic        tx_en_n;
    logic        tx_er_n;
    logic        underrun_n;

    assign in_ready = (state == SFD) || (state == DATA);
    assign busy     = (state != IDLE);
    assign byte_inc = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + 11'd1;

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pre_cnt  <= '0;
            ifg_cnt  <= '0;
            byte_cnt <= '0;
            tx_data  <= '0;
            tx_en    <= 1'b0;
            tx_er    <= 1'b0;
            underrun <= 1'b0;
`ifdef TX_PAD_EN
            pad_cnt  <= '0;
`endif
        end else begin
            state    <= state_n;
            pre_cnt  <= pre_cnt_n;
            ifg_cnt  <= ifg_cnt_n;
            byte_cnt <= byte_cnt_n;
            tx_data  <= tx_data_n;
            tx_en    <= tx_en_n;
            tx_er    <= tx_er_n;
            underrun <= underrun_n;
`ifdef TX_PAD_EN
            pad_cnt  <= pad_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        pre_cnt_n  = pre_cnt;
        ifg_cnt_n  = ifg_cnt;
        byte_cnt_n = byte_cnt;
        tx_data_n  = 8'h00;
        tx_en_n    = 1'b0;
        tx_er_n    = 1'b0;
        underrun_n = 1'b0;
`ifdef TX_PAD_EN
        pad_cnt_n  = pad_cnt;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n    = PRE;
                    pre_cnt_n  = PRE_LOAD;
                    byte_cnt_n = '0;
                    tx_en_n    = 1'b1;
                    tx_data_n  = PRE_BYTE;
                end
            end
            PRE: begin
                tx_en_n = 1'b1;
                if (pre_cnt == 4'd0) begin
                    state_n   = SFD;
                    tx_data_n = SFD_BYTE;
                end else begin
                    pre_cnt_n = pre_cnt - 4'd1;
                    tx_data_n = PRE_BYTE;
                end
            end
            SFD, DATA: begin
                tx_en_n = 1'b1;
                if (in_valid) begin
                    tx_data_n  = in_data;
                    byte_cnt_n = byte_inc;
                    if (in_last) begin
`ifdef TX_PAD_EN
                        if (byte_inc < MIN_CNT) begin
                            state_n   = PAD;
                            pad_cnt_n = MIN_CNT - byte_inc;
                        end else begin
                            state_n   = IFG;
                            ifg_cnt_n = IFG_LOAD;
                        end
`else
                        state_n   = IFG;
                        ifg_cnt_n = IFG_LOAD;
`endif
                    end else begin
                        state_n = DATA;
                    end
                end else begin
                    // Upstream starved mid-body: one error byte, then straight to the gap, no padding.
                    tx_er_n    = 1'b1;
                    underrun_n = 1'b1;
                    state_n    = IFG;
                    ifg_cnt_n  = IFG_LOAD;
                end
            end
`ifdef TX_PAD_EN
            PAD: begin
                tx_en_n   = 1'b1;
                pad_cnt_n = pad_cnt - 11'd1;
                if (pad_cnt == 11'd1) begin
                    state_n   = IFG;
                    ifg_cnt_n = IFG_LOAD;
                end
            end
`endif
            IFG: begin
                // First IFG cycle still shows the final byte; the load value covers the IFG_LEN low cycles after it.
                if (ifg_cnt == 8'd0) begin
                    state_n = IDLE;
                end else begin
                    ifg_cnt_n = ifg_cnt - 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_preamble_ins.sv
// Table-driven bench for tx_preamble_ins: per-cycle {inputs, expected outputs} rows plus a hand-written async reset sequence.
module tb_tx_preamble_ins;

    localparam int PRE_LEN = 7;
    localparam int IFG_LEN = 12;
    localparam int MIN_LEN = 60;

    logic       tx_clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_er;
    logic       busy;
    logic       underrun;

    int checks = 0;
    int errors = 0;

    tx_preamble_ins #(
        .PRE_LEN(PRE_LEN),
        .IFG_LEN(IFG_LEN),
        .MIN_LEN(MIN_LEN)
    ) dut (
        .tx_clk  (tx_clk),
        .reset   (reset),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_last (in_last),
        .in_ready(in_ready),
        .tx_data (tx_data),
        .tx_en   (tx_en),
        .tx_er   (tx_er),
        .busy    (busy),
        .underrun(underrun)
    );

    always #4 tx_clk = ~tx_clk;

    typedef struct {
        logic       v;
        logic       l;
        logic [7:0] d;
        logic       en;
        logic       er;
        logic [7:0] txd;
        logic       rdy;
        logic       bsy;
        logic       ur;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string tag, logic v, logic l, logic [7:0] d,
                                logic en, logic er, logic [7:0] txd,
                                logic rdy, logic bsy, logic ur);
        vec_t r;
        r.v = v; r.l = l; r.d = d;
        r.en = en; r.er = er; r.txd = txd;
        r.rdy = rdy; r.bsy = bsy; r.ur = ur;
        r.tag = tag;
        vecs.push_back(r);
    endfunction

    function automatic void add_idle(string tag, logic l);
        add(tag, 1'b0, l, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endfunction

    // T0 row (still idle on the pins) followed by the preamble rows
    function automatic void add_start(string tag);
        add(tag, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < PRE_LEN; i++)
            add(tag, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0);
    endfunction

    function automatic void add_gap(string tag, logic v);
        for (int i = 0; i < IFG_LEN; i++)
            add(tag, v, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vecs();
        logic [12:0] act, exp;
        foreach (vecs[i]) begin
            @(negedge tx_clk);
            in_valid = vecs[i].v;
            in_last  = vecs[i].l;
            in_data  = vecs[i].d;
            act = {tx_en, tx_er, tx_data, in_ready, busy, underrun};
            exp = {vecs[i].en, vecs[i].er, vecs[i].txd, vecs[i].rdy, vecs[i].bsy, vecs[i].ur};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s row %0d en/er/data/rdy/busy/ur got %b/%b/%h/%b/%b/%b expected %b/%b/%h/%b/%b/%b",
                         vecs[i].tag, i, act[12], act[11], act[10:3], act[2], act[1], act[0],
                         exp[12], exp[11], exp[10:3], exp[2], exp[1], exp[0]);
            end
        end
        vecs.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge tx_clk);
        check("reset_outputs", {19'd0, tx_en, tx_er, tx_data, in_ready, busy, underrun}, 32'd0);
        reset = 1'b0;

        // idle, including in_last without in_valid
        add_idle("idle", 1'b0);
        add_idle("idle_last_only", 1'b1);
        add_idle("idle", 1'b0);

        // 4-byte body
        add_start("f4");
        add("f4", 1, 0, 8'h11, 1, 0, 8'hD5, 1, 1, 0);
        add("f4", 1, 0, 8'h22, 1, 0, 8'h11, 1, 1, 0);
        add("f4", 1, 0, 8'h33, 1, 0, 8'h22, 1, 1, 0);
        add("f4", 1, 1, 8'h44, 1, 0, 8'h33, 1, 1, 0);
        add("f4", 0, 0, 8'h00, 1, 0, 8'h44, 0, 1, 0);
        add_gap("f4_ifg", 1'b0);
        add_idle("f4_done", 1'b0);

        // back-to-back, in_valid held high through the gap
        add_start("b2b_a");
        add("b2b_a", 1, 0, 8'hAA, 1, 0, 8'hD5, 1, 1, 0);
        add("b2b_a", 1, 1, 8'hBB, 1, 0, 8'hAA, 1, 1, 0);
        add("b2b_a", 1, 0, 8'hEE, 1, 0, 8'hBB, 0, 1, 0);
        add_gap("b2b_a_ifg", 1'b1);
        // single-byte body, last in the SFD cycle
        add_start("b2b_b");
        add("b2b_b", 1, 1, 8'h5A, 1, 0, 8'hD5, 1, 1, 0);
        add("b2b_b", 1, 0, 8'hEE, 1, 0, 8'h5A, 0, 1, 0);
        add_gap("b2b_b_ifg", 1'b0);
        add_idle("b2b_done", 1'b0);

        // underrun after 3 bytes; in_last without in_valid does not end the frame
        add_start("ur");
        add("ur", 1, 0, 8'h01, 1, 0, 8'hD5, 1, 1, 0);
        add("ur", 1, 0, 8'h02, 1, 0, 8'h01, 1, 1, 0);
        add("ur", 1, 0, 8'h03, 1, 0, 8'h02, 1, 1, 0);
        add("ur", 0, 1, 8'h04, 1, 0, 8'h03, 1, 1, 0);
        add("ur_err", 0, 0, 8'h04, 1, 1, 8'h00, 0, 1, 1);
        add_gap("ur_ifg", 1'b0);
        add_idle("ur_done", 1'b0);
        run_vecs();

        // reset asserted mid-body
        add_start("rst_pre");
        add("rst_pre", 1, 0, 8'hA1, 1, 0, 8'hD5, 1, 1, 0);
        add("rst_pre", 1, 0, 8'hA2, 1, 0, 8'hA1, 1, 1, 0);
        add("rst_pre", 1, 0, 8'hA3, 1, 0, 8'hA2, 1, 1, 0);
        run_vecs();
        @(posedge tx_clk);
        #2;
        check("mid_body_data", {23'd0, tx_en, tx_data}, {23'd0, 1'b1, 8'hA3});
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {19'd0, tx_en, tx_er, tx_data, in_ready, busy, underrun}, 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge tx_clk);
        @(negedge tx_clk);
        reset = 1'b0;

        add_idle("post_rst", 1'b0);
        add_start("post_rst");
        add("post_rst", 1, 0, 8'hC1, 1, 0, 8'hD5, 1, 1, 0);
        add("post_rst", 1, 1, 8'hC2, 1, 0, 8'hC1, 1, 1, 0);
        add("post_rst", 0, 0, 8'h00, 1, 0, 8'hC2, 0, 1, 0);
        add_gap("post_rst_ifg", 1'b0);
        add_idle("post_rst_done", 1'b0);
        run_vecs();

`ifdef TX_PAD_EN
        // short body padded with zeros up to MIN_LEN
        add_start("pad4");
        add("pad4", 1, 0, 8'h11, 1, 0, 8'hD5, 1, 1, 0);
        add("pad4", 1, 0, 8'h22, 1, 0, 8'h11, 1, 1, 0);
        add("pad4", 1, 0, 8'h33, 1, 0, 8'h22, 1, 1, 0);
        add("pad4", 1, 1, 8'h44, 1, 0, 8'h33, 1, 1, 0);
        add("pad4", 0, 0, 8'h00, 1, 0, 8'h44, 0, 1, 0);
        for (int i = 0; i < MIN_LEN - 4; i++)
            add("pad4_fill", 0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0);
        add_gap("pad4_ifg", 1'b0);
        add_idle("pad4_done", 1'b0);

        // 64-byte body, no padding
        add_start("len64");
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b, p;
            b = 8'(i + 1);
            p = (i == 0) ? 8'hD5 : 8'(i);
            add("len64", 1, (i == 63), b, 1, 0, p, 1, 1, 0);
        end
        add("len64", 0, 0, 8'h00, 1, 0, 8'd64, 0, 1, 0);
        add_gap("len64_ifg", 1'b0);
        add_idle("len64_done", 1'b0);
        run_vecs();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
